// File: rtl/tau_pkg.sv
// Shared types and default sizes for the tau GEMM controller and its helpers.
package tau_pkg;

    // Sequencer states: wait for a slice, pulse the array, wait for results, signal completion.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } ctrl_state_t;

    localparam int DEF_DIM      = 16;
    localparam int DEF_BITWIDTH = 8;
    localparam int DEF_K_STEPS  = 16;
    localparam int DEF_TIMEOUT  = 1024;

endpackage

// File: rtl/tau_wait_timer.sv
// Counts cycles spent waiting on the MAC array. The first counted cycle is
// flagged as blank (the array is still dropping its old valid), and the
// TIMEOUT-th counted cycle is flagged as expired.
module tau_wait_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic blank_o,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear wins over counting; the count parks at the expire value.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Cycle counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign blank_o  = (cnt_q == '0);
    assign expire_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/tau_gemm_ctrl.sv
// Sequencer for the DIM x DIM tau_mac array: takes one K-slice per handshake,
// holds it on the operand buses, pulses start, waits for every MAC to report
// valid, and pulses finished after K_STEPS slices.
//
// Handshake: a slice is transferred in a cycle where slice_valid_i and
// slice_ready_o are both high; slice_ready_o is only high in IDLE and is
// forced low while abort_i is asserted, so a transfer is never half-taken.
module tau_gemm_ctrl
    import tau_pkg::*;
#(
    parameter int DIM      = DEF_DIM,
    parameter int BITWIDTH = DEF_BITWIDTH,
    parameter int K_STEPS  = DEF_K_STEPS,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    localparam int SW      = DIM * BITWIDTH,
    localparam int KW      = $clog2(K_STEPS) + 1
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    input  logic            slice_valid_i,
    output logic            slice_ready_o,
    input  logic [SW-1:0]   slice_a_i,
    input  logic [SW-1:0]   slice_b_i,
    input  logic            abort_i,
    input  logic [DIM*DIM-1:0] mac_valid_i,
    output logic [SW-1:0]   active_in0_o,
    output logic [SW-1:0]   active_in1_o,
    output logic            start_o,
    output logic            mac_clear_o,
    output logic [KW-1:0]   k_idx_o,
    output logic            busy_o,
    output logic            finished_o,
    output logic            timeout_err_o,
    output ctrl_state_t     dbg_state_o
);

    ctrl_state_t state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [SW-1:0] in0_q, in0_d;
    logic [SW-1:0] in1_q, in1_d;
    logic          to_q, to_d;
    logic          rdy_en_q;

    logic all_valid;
    logic accept;
    logic tmr_blank;
    logic tmr_expire;

    assign all_valid = &mac_valid_i;
    assign accept    = slice_valid_i && slice_ready_o;

    tau_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_ni   (reset_n_i),
        .clear_i  (state_q == FIRE),
        .en_i     (state_q == WAIT),
        .blank_o  (tmr_blank),
        .expire_o (tmr_expire)
    );

    // Next-state, slice index, operand capture and sticky timeout; abort overrides all.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        in0_d   = in0_q;
        in1_d   = in1_q;
        to_d    = to_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    in0_d   = slice_a_i;
                    in1_d   = slice_b_i;
                    state_d = FIRE;
                    if (k_q == '0) begin
                        to_d = 1'b0;
                    end
                end
            end
            FIRE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (!tmr_blank && all_valid) begin
                    if (k_q == KW'(K_STEPS - 1)) begin
                        state_d = DONE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = IDLE;
                    end
                end else if (tmr_expire) begin
                    to_d    = 1'b1;
                    k_d     = '0;
                    state_d = IDLE;
                end
            end
            DONE: begin
                k_d     = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort_i) begin
            state_d = IDLE;
            k_d     = '0;
            to_d    = to_q;
        end
    end

    // Controller state registers; rdy_en_q holds ready low until the first cycle after reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            k_q      <= '0;
            in0_q    <= '0;
            in1_q    <= '0;
            to_q     <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            in0_q    <= in0_d;
            in1_q    <= in1_d;
            to_q     <= to_d;
            rdy_en_q <= 1'b1;
        end
    end

    assign slice_ready_o = (state_q == IDLE) && rdy_en_q && !abort_i;
    assign start_o       = (state_q == FIRE);
    assign mac_clear_o   = (state_q == FIRE) && (k_q == '0);
    assign finished_o    = (state_q == DONE);
    assign busy_o        = (k_q != '0) || (state_q != IDLE);
    assign k_idx_o       = k_q;
    assign active_in0_o  = in0_q;
    assign active_in1_o  = in1_q;
    assign timeout_err_o = to_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_tau_gemm_ctrl.sv
// Directed bench for tau_gemm_ctrl with DIM=4, K_STEPS=2, TIMEOUT=8.
// Each table row gives the inputs for one cycle and the outputs expected in
// that same cycle; a hand-written sequence covers reset during a GEMM.
module tb_tau_gemm_ctrl;
    import tau_pkg::*;

    localparam int DIM = 4;
    localparam int BW  = 8;
    localparam int KS  = 2;
    localparam int TO  = 8;
    localparam int SW  = DIM * BW;
    localparam int KW  = $clog2(KS) + 1;
    localparam logic [15:0] M = 16'hFFFF;
    localparam logic [15:0] Z = 16'h0000;
    localparam logic [15:0] P = 16'h7FFF;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            slice_valid;
    logic            slice_ready;
    logic [SW-1:0]   slice_a;
    logic [SW-1:0]   slice_b;
    logic            abort;
    logic [DIM*DIM-1:0] mac_valid;
    logic [SW-1:0]   active_in0;
    logic [SW-1:0]   active_in1;
    logic            start;
    logic            mac_clear;
    logic [KW-1:0]   k_idx;
    logic            busy;
    logic            finished;
    logic            timeout_err;
    ctrl_state_t     dbg_state;

    tau_gemm_ctrl #(
        .DIM      (DIM),
        .BITWIDTH (BW),
        .K_STEPS  (KS),
        .TIMEOUT  (TO)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .slice_valid_i (slice_valid),
        .slice_ready_o (slice_ready),
        .slice_a_i     (slice_a),
        .slice_b_i     (slice_b),
        .abort_i       (abort),
        .mac_valid_i   (mac_valid),
        .active_in0_o  (active_in0),
        .active_in1_o  (active_in1),
        .start_o       (start),
        .mac_clear_o   (mac_clear),
        .k_idx_o       (k_idx),
        .busy_o        (busy),
        .finished_o    (finished),
        .timeout_err_o (timeout_err),
        .dbg_state_o   (dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        int          si;
        logic        ab;
        logic [15:0] mac;
        ctrl_state_t st;
        logic        rdy;
        logic        stt;
        logic        clr;
        int          k;
        logic        busy;
        logic        fin;
        logic        to;
        int          ein;
    } vec_t;

    vec_t            vec_q[$];
    logic [SW-1:0]   sa[10];
    logic [SW-1:0]   sb[10];
    int              n_checks = 0;
    int              n_errors = 0;
    int              cur_row  = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s row %0d actual=%0h required=%0h", name, cur_row, act, exp);
        end
    endtask

    task automatic add(input logic v, input int si, input logic ab, input logic [15:0] mac,
                       input ctrl_state_t st, input logic rdy, input logic stt, input logic clr,
                       input int k, input logic bsy, input logic fin, input logic to, input int ein);
        vec_t r;
        r.v = v; r.si = si; r.ab = ab; r.mac = mac; r.st = st; r.rdy = rdy; r.stt = stt;
        r.clr = clr; r.k = k; r.busy = bsy; r.fin = fin; r.to = to; r.ein = ein;
        vec_q.push_back(r);
    endtask

    function automatic logic [SW-1:0] exp_a(input int idx);
        return (idx < 0) ? '0 : sa[idx];
    endfunction

    function automatic logic [SW-1:0] exp_b(input int idx);
        return (idx < 0) ? '0 : sb[idx];
    endfunction

    task automatic check_outputs(input ctrl_state_t st, input logic rdy, input logic stt,
                                 input logic clr, input int k, input logic bsy, input logic fin,
                                 input logic to, input int ein);
        chk("state",       64'(dbg_state),   64'(st));
        chk("slice_ready", 64'(slice_ready), 64'(rdy));
        chk("start",       64'(start),       64'(stt));
        chk("mac_clear",   64'(mac_clear),   64'(clr));
        chk("k_idx",       64'(k_idx),       64'(k));
        chk("busy",        64'(busy),        64'(bsy));
        chk("finished",    64'(finished),    64'(fin));
        chk("timeout_err", 64'(timeout_err), 64'(to));
        chk("active_in0",  64'(active_in0),  64'(exp_a(ein)));
        chk("active_in1",  64'(active_in1),  64'(exp_b(ein)));
    endtask

    initial begin
        for (int i = 0; i < 10; i++) begin
            sa[i] = 32'h10203040 + 32'h01010101 * (i + 1);
            sb[i] = ~sa[i] ^ 32'(i * 7);
        end

        //   v si ab mac state rdy stt clr k busy fin to ein
        // One GEMM, all-valid 3 cycles after start.
        add(1, 0, 0, Z, IDLE, 1, 0, 0, 0, 0, 0, 0, -1);
        add(0, 0, 0, Z, FIRE, 0, 1, 1, 0, 1, 0, 0, 0);
        add(0, 0, 0, Z, WAIT, 0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, Z, WAIT, 0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, M, WAIT, 0, 0, 0, 0, 1, 0, 0, 0);
        add(1, 1, 0, Z, IDLE, 1, 0, 0, 1, 1, 0, 0, 0);
        add(0, 1, 0, Z, FIRE, 0, 1, 0, 1, 1, 0, 0, 1);
        add(0, 1, 0, Z, WAIT, 0, 0, 0, 1, 1, 0, 0, 1);
        add(0, 1, 0, Z, WAIT, 0, 0, 0, 1, 1, 0, 0, 1);
        add(0, 1, 0, M, WAIT, 0, 0, 0, 1, 1, 0, 0, 1);
        add(0, 1, 0, Z, DONE, 0, 0, 0, 1, 1, 1, 0, 1);
        add(0, 1, 0, Z, IDLE, 1, 0, 0, 0, 0, 0, 0, 1);
        // mac_valid held high: blank cycle makes each WAIT 2 cycles; slice_valid held across DONE.
        add(1, 2, 0, M, IDLE, 1, 0, 0, 0, 0, 0, 0, 1);
        add(1, 2, 0, M, FIRE, 0, 1, 1, 0, 1, 0, 0, 2);
        add(1, 2, 0, M, WAIT, 0, 0, 0, 0, 1, 0, 0, 2);
        add(1, 2, 0, M, WAIT, 0, 0, 0, 0, 1, 0, 0, 2);
        add(1, 3, 0, M, IDLE, 1, 0, 0, 1, 1, 0, 0, 2);
        add(1, 3, 0, M, FIRE, 0, 1, 0, 1, 1, 0, 0, 3);
        add(1, 3, 0, M, WAIT, 0, 0, 0, 1, 1, 0, 0, 3);
        add(1, 3, 0, M, WAIT, 0, 0, 0, 1, 1, 0, 0, 3);
        add(1, 4, 0, M, DONE, 0, 0, 0, 1, 1, 1, 0, 3);
        add(1, 4, 0, M, IDLE, 1, 0, 0, 0, 0, 0, 0, 3);
        add(0, 4, 0, P, FIRE, 0, 1, 1, 0, 1, 0, 0, 4);
        // One MAC never valid: timeout after 8 WAIT cycles.
        for (int i = 0; i < TO; i++) begin
            add(0, 0, 0, P, WAIT, 0, 0, 0, 0, 1, 0, 0, 4);
        end
        add(0, 0, 0, P, IDLE, 1, 0, 0, 0, 0, 0, 1, 4);
        add(1, 5, 0, Z, IDLE, 1, 0, 0, 0, 0, 0, 1, 4);
        add(0, 5, 0, Z, FIRE, 0, 1, 1, 0, 1, 0, 0, 5);
        add(0, 5, 0, Z, WAIT, 0, 0, 0, 0, 1, 0, 0, 5);
        add(0, 5, 0, M, WAIT, 0, 0, 0, 0, 1, 0, 0, 5);
        // Abort in WAIT at k=1, then abort in IDLE against a valid slice.
        add(1, 6, 0, Z, IDLE, 1, 0, 0, 1, 1, 0, 0, 5);
        add(0, 6, 0, Z, FIRE, 0, 1, 0, 1, 1, 0, 0, 6);
        add(0, 6, 0, Z, WAIT, 0, 0, 0, 1, 1, 0, 0, 6);
        add(0, 6, 1, M, WAIT, 0, 0, 0, 1, 1, 0, 0, 6);
        add(0, 6, 0, M, IDLE, 1, 0, 0, 0, 0, 0, 0, 6);
        add(1, 7, 1, Z, IDLE, 0, 0, 0, 0, 0, 0, 0, 6);
        add(1, 7, 0, Z, IDLE, 1, 0, 0, 0, 0, 0, 0, 6);
        add(0, 7, 0, Z, FIRE, 0, 1, 1, 0, 1, 0, 0, 7);
        add(0, 7, 0, Z, WAIT, 0, 0, 0, 0, 1, 0, 0, 7);
        add(0, 7, 0, M, WAIT, 0, 0, 0, 0, 1, 0, 0, 7);
        add(0, 7, 0, Z, IDLE, 1, 0, 0, 1, 1, 0, 0, 7);
    end

    // Reset, table replay, reset mid-GEMM, report.
    initial begin
        reset_n     = 1'b0;
        slice_valid = 1'b0;
        slice_a     = '0;
        slice_b     = '0;
        abort       = 1'b0;
        mac_valid   = '0;

        repeat (3) @(negedge clk);
        #1;
        check_outputs(IDLE, 0, 0, 0, 0, 0, 0, 0, -1);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("ready_before_first_edge", 64'(slice_ready), 64'(0));

        foreach (vec_q[i]) begin
            @(negedge clk);
            cur_row     = i;
            slice_valid = vec_q[i].v;
            slice_a     = sa[vec_q[i].si];
            slice_b     = sb[vec_q[i].si];
            abort       = vec_q[i].ab;
            mac_valid   = vec_q[i].mac;
            #1;
            check_outputs(vec_q[i].st, vec_q[i].rdy, vec_q[i].stt, vec_q[i].clr, vec_q[i].k,
                          vec_q[i].busy, vec_q[i].fin, vec_q[i].to, vec_q[i].ein);
        end

        // Reset while a k=1 slice is in FIRE: everything returns to reset values at once.
        @(negedge clk);
        cur_row     = 1000;
        slice_valid = 1'b1;
        slice_a     = sa[8];
        slice_b     = sb[8];
        mac_valid   = '0;
        #1;
        check_outputs(IDLE, 1, 0, 0, 1, 1, 0, 0, 7);
        @(negedge clk);
        cur_row     = 1001;
        slice_valid = 1'b0;
        #1;
        check_outputs(FIRE, 0, 1, 0, 1, 1, 0, 0, 8);
        #2;
        reset_n = 1'b0;
        #1;
        cur_row = 1002;
        check_outputs(IDLE, 0, 0, 0, 0, 0, 0, 0, -1);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cur_row = 1003 + i;
            #1;
            check_outputs(IDLE, 1, 0, 0, 0, 0, 0, 0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
